// File: rtl/ar_pkg.sv
// Shared constants and FSM state encoding for the centroid divide scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ar_pkg;

    localparam int NUM_OBJ = 4;
    localparam int SUM_W   = 32;
    localparam int CNT_W   = 8;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_DIV_START = 3'd1;
    localparam logic [2:0] ST_DIV_WAIT  = 3'd2;
    localparam logic [2:0] ST_STORE     = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        DIV_START = ST_DIV_START,
        DIV_WAIT  = ST_DIV_WAIT,
        STORE     = ST_STORE,
        DONE      = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Latency: done pulses WIDTH cycles after the start edge (first bit is resolved on that edge).
// Backpressure: none; caller must not restart before done and must never divide by zero.
module serial_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done
);

    localparam int CNT_BITS = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]    rem_q;
    logic [WIDTH-1:0]    quo_q;
    logic [WIDTH-1:0]    dvs_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic                running;

    logic [WIDTH-1:0]    step_rem_in;
    logic [WIDTH-1:0]    step_quo_in;
    logic [WIDTH-1:0]    step_dvs;
    logic [WIDTH:0]      trial;
    logic [WIDTH:0]      diff;
    logic                fits;
    logic [WIDTH-1:0]    step_rem;
    logic [WIDTH-1:0]    step_quo;

    // One restoring step; on start it works straight from the operands so the
    // first quotient bit costs no extra load cycle.
    always_comb begin
        step_rem_in = rem_q;
        step_quo_in = quo_q;
        step_dvs    = dvs_q;
        if (start) begin
            step_rem_in = '0;
            step_quo_in = dividend;
            step_dvs    = divisor;
        end
        trial    = {step_rem_in, step_quo_in[WIDTH-1]};
        diff     = trial - {1'b0, step_dvs};
        fits     = (trial >= {1'b0, step_dvs});
        step_rem = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        step_quo = {step_quo_in[WIDTH-2:0], fits};
    end

    // Iteration registers; done is raised together with the last quotient bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q   <= step_rem;
                quo_q   <= step_quo;
                dvs_q   <= divisor;
                cnt_q   <= CNT_BITS'(WIDTH - 1);
                running <= 1'b1;
            end else if (running) begin
                rem_q <= step_rem;
                quo_q <= step_quo;
                cnt_q <= cnt_q - CNT_BITS'(1);
                if (cnt_q == CNT_BITS'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/centroid_div_scheduler.sv
// Runs all per-colour centroid divisions (x then y per colour) through one shared serial divider.
// Latency: start to done = 2*NUM_OBJ*(SUM_W+2)+1 cycles, minus SUM_W per zero-count job.
// Backpressure: none; start is honoured only when idle, otherwise dropped; consumers qualify on done.
module centroid_div_scheduler
    import ar_pkg::*;
#(
    parameter int P_NUM_OBJ = NUM_OBJ,
    parameter int P_SUM_W   = SUM_W,
    parameter int P_CNT_W   = CNT_W,
    parameter int P_X_W     = X_W,
    parameter int P_Y_W     = Y_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [P_NUM_OBJ*P_SUM_W-1:0]   sums_x,
    input  logic [P_NUM_OBJ*P_SUM_W-1:0]   sums_y,
    input  logic [P_NUM_OBJ*P_CNT_W-1:0]   counts,
    output logic [P_NUM_OBJ*P_X_W-1:0]     avg_x,
    output logic [P_NUM_OBJ*P_Y_W-1:0]     avg_y,
    output logic [P_NUM_OBJ-1:0]           valid,
    output logic                           busy,
    output logic                           done
);

    localparam int JOBS  = 2 * P_NUM_OBJ;
    localparam int JOB_W = $clog2(JOBS);

    state_t state;
    state_t state_nxt;

    logic [P_SUM_W-1:0] sh_x   [P_NUM_OBJ];
    logic [P_SUM_W-1:0] sh_y   [P_NUM_OBJ];
    logic [P_CNT_W-1:0] sh_cnt [P_NUM_OBJ];

    logic [JOB_W-1:0]   job;
    logic [JOB_W-2:0]   col;
    logic               is_y;
    logic               job_skip;
    logic               last_job;

    logic               div_start;
    logic               div_done;
    logic [P_SUM_W-1:0] div_dividend;
    logic [P_SUM_W-1:0] div_divisor;
    logic [P_SUM_W-1:0] div_quotient;
    logic [P_X_W-1:0]   sat_x;
    logic [P_Y_W-1:0]   sat_y;

    // Job j maps to colour j>>1; odd jobs are the y division.
    assign col      = job[JOB_W-1:1];
    assign is_y     = job[0];
    assign job_skip = (sh_cnt[col] == '0);
    assign last_job = (job == JOB_W'(JOBS - 1));

    assign div_dividend = is_y ? sh_y[col] : sh_x[col];
    assign div_divisor  = {{(P_SUM_W-P_CNT_W){1'b0}}, sh_cnt[col]};

    // Averages that do not fit the coordinate field clamp to all-ones.
    assign sat_x = (|div_quotient[P_SUM_W-1:P_X_W]) ? '1 : div_quotient[P_X_W-1:0];
    assign sat_y = (|div_quotient[P_SUM_W-1:P_Y_W]) ? '1 : div_quotient[P_Y_W-1:0];

    serial_divider #(
        .WIDTH (P_SUM_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quotient),
        .done     (div_done)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-state strobes; zero-count jobs bypass the divider.
    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DIV_START;
                end
            end
            DIV_START: begin
                if (job_skip) begin
                    state_nxt = STORE;
                end else begin
                    div_start = 1'b1;
                    state_nxt = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                if (div_done) begin
                    state_nxt = STORE;
                end
            end
            STORE: begin
                state_nxt = last_job ? DONE : DIV_START;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Snapshot of the accumulators so they can move on to the next frame mid-run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < P_NUM_OBJ; k++) begin
                sh_x[k]   <= '0;
                sh_y[k]   <= '0;
                sh_cnt[k] <= '0;
            end
        end else if (state == IDLE && start) begin
            for (int k = 0; k < P_NUM_OBJ; k++) begin
                sh_x[k]   <= sums_x[k*P_SUM_W +: P_SUM_W];
                sh_y[k]   <= sums_y[k*P_SUM_W +: P_SUM_W];
                sh_cnt[k] <= counts[k*P_CNT_W +: P_CNT_W];
            end
        end
    end

    // Job counter: cleared on accepted start, advanced after each store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            job <= '0;
        end else if (state == IDLE && start) begin
            job <= '0;
        end else if (state == STORE && !last_job) begin
            job <= job + JOB_W'(1);
        end
    end

    // Output register file; the x job of each colour owns its valid bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avg_x <= '0;
            avg_y <= '0;
            valid <= '0;
        end else if (state == STORE) begin
            if (job_skip) begin
                if (!is_y) begin
                    valid[col] <= 1'b0;
                end
            end else if (is_y) begin
                avg_y[int'(col)*P_Y_W +: P_Y_W] <= sat_y;
            end else begin
                avg_x[int'(col)*P_X_W +: P_X_W] <= sat_x;
                valid[col]                      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_centroid_div_scheduler.sv
// Randomised and directed bench for centroid_div_scheduler against an arithmetic reference.
// Latency: checks the exact start-to-done cycle count of every run.
// Backpressure: exercises dropped starts while busy and an asynchronous reset mid-run.
module tb_centroid_div_scheduler;

    localparam int NOBJ = 4;
    localparam int SW   = 32;
    localparam int CW   = 8;
    localparam int XW   = 10;
    localparam int YW   = 9;
    localparam int XMAX = 1023;
    localparam int YMAX = 511;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic [NOBJ*SW-1:0]   sums_x;
    logic [NOBJ*SW-1:0]   sums_y;
    logic [NOBJ*CW-1:0]   counts;
    logic [NOBJ*XW-1:0]   avg_x;
    logic [NOBJ*YW-1:0]   avg_y;
    logic [NOBJ-1:0]      valid;
    logic                 busy;
    logic                 done;

    centroid_div_scheduler dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .sums_x (sums_x),
        .sums_y (sums_y),
        .counts (counts),
        .avg_x  (avg_x),
        .avg_y  (avg_y),
        .valid  (valid),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus values and the reference view of the published outputs.
    logic [SW-1:0] sx [NOBJ];
    logic [SW-1:0] sy [NOBJ];
    logic [CW-1:0] cn [NOBJ];
    longint        m_x [NOBJ];
    longint        m_y [NOBJ];
    logic [NOBJ-1:0] m_v;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NOBJ; k++) begin
            sums_x[k*SW +: SW] = sx[k];
            sums_y[k*SW +: SW] = sy[k];
            counts[k*CW +: CW] = cn[k];
        end
    endtask

    task automatic set_t1();
        cn = '{8'd10, 8'd20, 8'd40, 8'd80};
        sx = '{32'd1000, 32'd4000, 32'd8000, 32'd16000};
        sy = '{32'd500, 32'd2000, 32'd4000, 32'd8000};
    endtask

    task automatic model_clear();
        for (int k = 0; k < NOBJ; k++) begin
            m_x[k] = 0;
            m_y[k] = 0;
        end
        m_v = '0;
    endtask

    task automatic check_outputs(input string name);
        for (int k = 0; k < NOBJ; k++) begin
            check_eq($sformatf("%s avg_x[%0d]", name, k), longint'(avg_x[k*XW +: XW]), m_x[k]);
            check_eq($sformatf("%s avg_y[%0d]", name, k), longint'(avg_y[k*YW +: YW]), m_y[k]);
        end
        check_eq($sformatf("%s valid", name), longint'(valid), longint'(m_v));
    endtask

    // One run: inj = cycle to re-pulse start (0 none), pulse_done = re-pulse in the
    // done cycle, scramble = change inputs after the latch, rst_at = reset cycle (0 none).
    task automatic do_run(input string name, input int inj, input bit pulse_done,
                          input bit scramble, input int rst_at);
        logic [SW-1:0] lx [NOBJ];
        logic [SW-1:0] ly [NOBJ];
        logic [CW-1:0] lc [NOBJ];
        int  exp_cyc;
        int  n;
        bit  seen;
        longint q;

        @(negedge clk);
        drive_inputs();
        lx = sx;
        ly = sy;
        lc = cn;
        start = 1'b1;
        exp_cyc = 1;
        for (int k = 0; k < NOBJ; k++) begin
            exp_cyc += (lc[k] != 0) ? 2 * (SW + 2) : 4;
        end

        n = 0;
        seen = 1'b0;
        while (!seen && n < 1000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = 1'b0;
            if (scramble && n == 1) begin
                for (int k = 0; k < NOBJ; k++) begin
                    sums_x[k*SW +: SW] = $urandom;
                    sums_y[k*SW +: SW] = $urandom;
                    counts[k*CW +: CW] = CW'($urandom);
                end
            end
            if (n == inj) begin
                start = 1'b1;
            end
            if (n == rst_at) begin
                reset = 1'b1;
                #1;
                model_clear();
                check_outputs({name, " async clr"});
                check_eq({name, " busy in reset"}, longint'(busy), 0);
                check_eq({name, " done in reset"}, longint'(done), 0);
                @(negedge clk);
                reset = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_eq({name, " no done after reset"}, longint'(done), 0);
                end
                return;
            end
            if (done) begin
                seen = 1'b1;
            end
        end

        if (!seen) begin
            check_eq({name, " done timeout"}, 0, 1);
            return;
        end

        check_eq({name, " latency"}, n, exp_cyc);
        check_eq({name, " busy at done"}, longint'(busy), 1);

        for (int k = 0; k < NOBJ; k++) begin
            if (lc[k] != 0) begin
                q = longint'(lx[k]) / longint'(lc[k]);
                m_x[k] = (q > XMAX) ? XMAX : q;
                q = longint'(ly[k]) / longint'(lc[k]);
                m_y[k] = (q > YMAX) ? YMAX : q;
                m_v[k] = 1'b1;
            end else begin
                m_v[k] = 1'b0;
            end
        end
        check_outputs(name);

        if (pulse_done) begin
            start = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_eq({name, " done width"}, longint'(done), 0);
        check_eq({name, " busy after done"}, longint'(busy), 0);
        if (pulse_done || inj != 0) begin
            repeat (3) begin
                @(negedge clk);
                check_eq({name, " no second run"}, longint'(busy), 0);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        sums_x = '0;
        sums_y = '0;
        counts = '0;
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_outputs("reset");
        check_eq("reset busy", longint'(busy), 0);
        check_eq("reset done", longint'(done), 0);

        // Basic four-colour run.
        set_t1();
        do_run("t1", 0, 1'b0, 1'b0, 0);

        // Seed avg_x[2]=77, then skip colour 2.
        set_t1();
        cn[2] = 8'd1;
        sx[2] = 32'd77;
        sy[2] = 32'd33;
        do_run("t2 seed", 0, 1'b0, 1'b0, 0);
        set_t1();
        cn[2] = 8'd0;
        do_run("t2", 0, 1'b0, 1'b0, 0);

        // All counts zero: nothing divided, averages held.
        for (int k = 0; k < NOBJ; k++) begin
            cn[k] = '0;
            sx[k] = $urandom;
            sy[k] = $urandom;
        end
        do_run("t3", 0, 1'b0, 1'b0, 0);

        // Saturation of both coordinates.
        set_t1();
        cn[0] = 8'd1;
        sx[0] = 32'd700000;
        sy[0] = 32'd600;
        do_run("t4", 0, 1'b0, 1'b0, 0);

        // Starts while busy are dropped.
        set_t1();
        do_run("t5", 100, 1'b1, 1'b0, 0);

        // Reset mid-run, then a clean run.
        set_t1();
        do_run("t6 reset", 0, 1'b0, 1'b0, 150);
        set_t1();
        do_run("t6 after", 0, 1'b0, 1'b0, 0);

        // Randomised runs with post-latch input churn and stray starts.
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < NOBJ; k++) begin
                cn[k] = ($urandom_range(0, 3) == 0) ? 8'd0 : CW'($urandom_range(1, 255));
                sx[k] = ($urandom_range(0, 4) == 0) ? $urandom
                        : $urandom_range(0, int'(cn[k]) * 1100);
                sy[k] = ($urandom_range(0, 4) == 0) ? $urandom
                        : $urandom_range(0, int'(cn[k]) * 600);
            end
            do_run($sformatf("rand%0d", r),
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 15)) : 0,
                   r[1], r[0], 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
